// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// sticky illegal-opcode and memory-timeout error flags.
module multicycle_control #(
    parameter int unsigned     OPW         = 5,
    parameter int unsigned     FNW         = 5,
    parameter logic [OPW-1:0]  HALT_OP     = '1,
    parameter int unsigned     MEM_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funccode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           ir_write,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           br_link,
    output logic           alu_frc,
    output logic [1:0]     alu_src,
    output logic [1:0]     alu_op,
    output logic [2:0]     branch,
    output logic [2:0]     state,
    output logic           instr_done,
    output logic           illegal,
    output logic           bus_err
);

    localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Counter value on the last wait cycle that may still complete normally
    localparam logic [CW-1:0] TO_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    localparam logic [OPW-1:0] OP_R   = OPW'(0);
    localparam logic [OPW-1:0] OP_I   = OPW'(1);
    localparam logic [OPW-1:0] OP_LS  = OPW'(2);
    localparam logic [OPW-1:0] OP_BR1 = OPW'(3);
    localparam logic [OPW-1:0] OP_BR2 = OPW'(4);
    localparam logic [OPW-1:0] OP_BR3 = OPW'(5);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [FNW-1:0] fn_q;
    logic [CW-1:0]  cnt_q;
    logic           illegal_q, bus_err_q;
    logic           set_illegal;
    logic           waiting, timeout, link, r_src2;
    state_t         done_next;

    assign waiting   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeout   = (MEM_TIMEOUT != 0) && waiting && (cnt_q == TO_LAST);
    assign link      = (op_q == OP_BR2) && (fn_q[2:0] == 3'b001);
    assign r_src2    = (fn_q == FNW'(4)) || (fn_q == FNW'(6)) || (fn_q == FNW'(8));
    assign done_next = run ? S_FETCH : S_IDLE;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

    // State, latched instruction fields, wait counter and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            fn_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funccode;
            end
            // Cleared whenever not stalled in FETCH/MEM, so every entry starts at zero
            if (waiting && !timeout && (MEM_TIMEOUT != 0))
                cnt_q <= cnt_q + CW'(1);
            else
                cnt_q <= '0;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (timeout)
                bus_err_q <= 1'b1;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        br_link     = 1'b0;
        alu_frc     = 1'b0;
        alu_src     = 2'b00;
        alu_op      = 2'b00;
        branch      = 3'b000;
        instr_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode == HALT_OP) begin
                    state_d = S_HALT;
                end else if (opcode <= OP_BR3) begin
                    state_d = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op  = 2'b01;
                        alu_src = r_src2 ? 2'b10 : 2'b00;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        alu_op  = 2'b10;
                        alu_src = 2'b01;
                        state_d = S_WB;
                    end
                    OP_LS: begin
                        alu_op  = 2'b11;
                        alu_src = 2'b01;
                        alu_frc = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BR1, OP_BR2, OP_BR3: begin
                        branch   = (op_q == OP_BR1) ? 3'b001 :
                                   (op_q == OP_BR2) ? 3'b010 : 3'b100;
                        pc_write = 1'b1;
                        if (link) begin
                            br_link = 1'b1;
                            state_d = S_WB;
                        end else begin
                            instr_done = 1'b1;
                            state_d    = done_next;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                iord    = 1'b1;
                alu_frc = 1'b1;
                alu_op  = 2'b11;
                if (fn_q[0])
                    mem_write = 1'b1;
                else
                    mem_read = 1'b1;
                if (mem_ready) begin
                    if (fn_q[0]) begin
                        instr_done = 1'b1;
                        state_d    = done_next;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LS);
                br_link    = link;
                instr_done = 1'b1;
                state_d    = done_next;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected cycle traces built from the
// control-unit rules, replayed against the DUT with randomized don't-care inputs.
module tb_multicycle_control;

    localparam logic [4:0] HALT_OP = 5'h1f;

    logic       clk = 1'b0;
    logic       rst, run, mem_ready;
    logic [4:0] opcode, funccode;
    logic       pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg;
    logic       reg_write, br_link, alu_frc, instr_done, illegal, bus_err;
    logic [1:0] alu_src, alu_op;
    logic [2:0] branch, state;
    logic [19:0] obs;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Expected output vector bit positions (see obs packing)
    localparam logic [19:0] M_PC   = 20'h80000;
    localparam logic [19:0] M_IR   = 20'h40000;
    localparam logic [19:0] M_IORD = 20'h20000;
    localparam logic [19:0] M_MRD  = 20'h10000;
    localparam logic [19:0] M_MWR  = 20'h08000;
    localparam logic [19:0] M_M2R  = 20'h04000;
    localparam logic [19:0] M_RW   = 20'h02000;
    localparam logic [19:0] M_BL   = 20'h01000;
    localparam logic [19:0] M_FRC  = 20'h00800;
    localparam logic [19:0] M_DONE = 20'h00001;

    typedef struct {
        logic [19:0] exp;
        logic        ill;
        logic        berr;
        logic        mr;
        logic        run;
        logic [4:0]  op;
        logic [4:0]  fn;
    } cyc_t;

    cyc_t tr[$];
    logic ill_m, berr_m;

    multicycle_control #(
        .OPW(5), .FNW(5), .HALT_OP(HALT_OP), .MEM_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funccode(funccode),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .br_link(br_link), .alu_frc(alu_frc),
        .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .state(state),
        .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
    );

    assign obs = {pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
                  reg_write, br_link, alu_frc, alu_src, alu_op, branch, state, instr_done};

    always #5 clk = ~clk;

    function automatic logic [19:0] f_st(int s);  return 20'(s) << 1; endfunction
    function automatic logic [19:0] f_br(int b);  return 20'(b) << 4; endfunction
    function automatic logic [19:0] f_aop(int a); return 20'(a) << 7; endfunction
    function automatic logic [19:0] f_src(int s); return 20'(s) << 9; endfunction
    function automatic logic rb(); return 1'($urandom_range(0, 1)); endfunction

    task automatic add(input logic [19:0] e, input logic mr, input logic rn,
                       input logic [4:0] op, input logic [4:0] fn);
        cyc_t c;
        c.exp = e; c.ill = ill_m; c.berr = berr_m;
        c.mr = mr; c.run = rn; c.op = op; c.fn = fn;
        tr.push_back(c);
    endtask

    task automatic addx(input logic [19:0] e, input logic mr, input logic rn);
        add(e, mr, rn, 5'($urandom), 5'($urandom));
    endtask

    // Expected trace of one instruction starting in FETCH
    task automatic gen_instr(input logic [4:0] op, input logic [4:0] fn,
                             input int flat, input int mlat, input logic last);
        logic        re;
        logic [19:0] e;
        int          src;
        re = !last;
        for (int i = 0; i < flat; i++) addx(M_MRD | f_st(1), 1'b0, rb());
        addx(M_MRD | M_IR | M_PC | f_st(1), 1'b1, rb());
        add(f_st(2), rb(), rb(), op, fn);
        if (op == HALT_OP) begin
            for (int i = 0; i < 6; i++) addx(f_st(6), rb(), rb());
            return;
        end
        if (op > 5) begin
            ill_m = 1'b1;
            return;
        end
        case (op)
            5'd0: begin
                src = (fn == 4 || fn == 6 || fn == 8) ? 2 : 0;
                addx(f_st(3) | f_aop(1) | f_src(src), rb(), rb());
                addx(f_st(5) | M_RW | M_DONE, rb(), re);
            end
            5'd1: begin
                addx(f_st(3) | f_aop(2) | f_src(1), rb(), rb());
                addx(f_st(5) | M_RW | M_DONE, rb(), re);
            end
            5'd2: begin
                addx(f_st(3) | f_aop(3) | f_src(1) | M_FRC, rb(), rb());
                e = f_st(4) | M_IORD | M_FRC | f_aop(3) | (fn[0] ? M_MWR : M_MRD);
                for (int i = 0; i < mlat; i++) addx(e, 1'b0, rb());
                if (fn[0]) begin
                    addx(e | M_DONE, 1'b1, re);
                end else begin
                    addx(e, 1'b1, rb());
                    addx(f_st(5) | M_RW | M_M2R | M_DONE, rb(), re);
                end
            end
            default: begin
                e = f_st(3) | f_br(1 << (op - 3)) | M_PC;
                if (op == 5'd4 && fn[2:0] == 3'b001) begin
                    addx(e | M_BL, rb(), rb());
                    addx(f_st(5) | M_RW | M_BL | M_DONE, rb(), re);
                end else begin
                    addx(e | M_DONE, rb(), re);
                end
            end
        endcase
    endtask

    task automatic play(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            run = tr[i].run; mem_ready = tr[i].mr;
            opcode = tr[i].op; funccode = tr[i].fn;
            @(negedge clk);
            n_cmp++;
            if (obs !== tr[i].exp) begin
                n_bad++;
                $display("FAIL %s cyc %0d outputs: got %h want %h", name, i, obs, tr[i].exp);
            end
            n_cmp++;
            if (illegal !== tr[i].ill || bus_err !== tr[i].berr) begin
                n_bad++;
                $display("FAIL %s cyc %0d flags ill/berr: got %b%b want %b%b",
                         name, i, illegal, bus_err, tr[i].ill, tr[i].berr);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b0; mem_ready = 1'b0;
        opcode = 5'($urandom); funccode = 5'($urandom);
        #1;
        n_cmp++;
        if (obs !== 20'h0 || illegal !== 1'b0 || bus_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: got %h %b%b want 00000 00", obs, illegal, bus_err);
        end
        run = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== 20'h0 || illegal !== 1'b0 || bus_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h %b%b want 00000 00", obs, illegal, bus_err);
        end
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        tr.delete();
        ill_m = 1'b0; berr_m = 1'b0;
    endtask

    task automatic test_directed();
        test_reset();
        addx(f_st(0), rb(), 1'b0);
        addx(f_st(0), rb(), 1'b1);
        gen_instr(5'd0, 5'd0, 0, 0, 1'b0);
        gen_instr(5'd0, 5'd8, 0, 0, 1'b0);
        gen_instr(5'd2, 5'd0, 1, 3, 1'b0);
        gen_instr(5'd4, 5'd1, 0, 0, 1'b0);
        gen_instr(5'd3, 5'd1, 0, 0, 1'b0);
        gen_instr(5'd4, 5'd9, 2, 0, 1'b0);
        gen_instr(5'd5, 5'd1, 0, 0, 1'b0);
        gen_instr(5'd1, 5'd6, 15, 0, 1'b0);
        gen_instr(5'd2, 5'd1, 0, 15, 1'b1);
        addx(f_st(0), rb(), 1'b0);
        addx(f_st(0), rb(), 1'b0);
        play("directed", tr.size());
    endtask

    task automatic test_random();
        logic [4:0] op;
        test_reset();
        addx(f_st(0), rb(), 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (k != 39 && $urandom_range(0, 7) == 0) op = 5'($urandom_range(6, 30));
            else op = 5'($urandom_range(0, 5));
            gen_instr(op, 5'($urandom),
                      ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3)),
                      k == 39);
        end
        addx(f_st(0), rb(), 1'b0);
        play("random", tr.size());
    endtask

    task automatic test_timeout_fetch();
        test_reset();
        addx(f_st(0), rb(), 1'b1);
        for (int i = 0; i < 16; i++) addx(M_MRD | f_st(1), 1'b0, rb());
        berr_m = 1'b1;
        for (int i = 0; i < 4; i++) addx(f_st(6), rb(), rb());
        play("timeout_fetch", tr.size());
    endtask

    task automatic test_timeout_mem();
        test_reset();
        addx(f_st(0), rb(), 1'b1);
        gen_instr(5'd2, 5'd2, 0, 16, 1'b0);
        void'(tr.pop_back());
        void'(tr.pop_back());
        berr_m = 1'b1;
        for (int i = 0; i < 4; i++) addx(f_st(6), rb(), rb());
        play("timeout_mem", tr.size());
    endtask

    task automatic test_illegal_halt();
        test_reset();
        addx(f_st(0), rb(), 1'b1);
        gen_instr(5'd7, 5'd3, 0, 0, 1'b0);
        gen_instr(HALT_OP, 5'd0, 1, 0, 1'b0);
        play("illegal_halt", tr.size());
        test_reset();
    endtask

    task automatic test_reset_mid_store();
        test_reset();
        addx(f_st(0), rb(), 1'b1);
        gen_instr(5'd2, 5'd1, 0, 10, 1'b0);
        play("mid_store", tr.size() - 1);
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_store_active: mem_write got %b want 1", mem_write);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_write !== 1'b0 || obs !== 20'h0) begin
            n_bad++;
            $display("FAIL mid_store_reset: mem_write got %b outputs %h want 0 00000", mem_write, obs);
        end
        test_reset();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0; funccode = '0;
        ill_m = 1'b0; berr_m = 1'b0;
        #2;
        test_reset();
        test_directed();
        test_random();
        test_timeout_fetch();
        test_timeout_mem();
        test_illegal_halt();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPW, default 5: opcode width.
REQ-002 Parameter FNW, default 5: funccode width; FNW SHALL be at least 4.
REQ-003 Parameter HALT_OP, default all-ones: opcode that halts the core.
REQ-004 Parameter MEM_TIMEOUT, default 16: maximum wait cycles per memory access; 0 disables the timeout.
REQ-005 Ports SHALL be as listed below:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  permits instruction issue.
- opcode  in  OPW  instruction opcode field; valid in the DECODE cycle.
- funccode  in  FNW  instruction function field; valid in the DECODE cycle.
- mem_ready  in  1  memory completes the current request.
- pc_write, ir_write  out  1  PC and IR load strobes.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- mem_read, mem_write, mem_to_reg, reg_write, br_link, alu_frc  out  1 each  datapath controls.
- alu_src  out  2  ALU operand select.
- alu_op  out  2  ALU operation class.
- branch  out  3  one-hot branch class.
- state  out  3  current state code.
- instr_done  out  1  one-cycle retire pulse.
- illegal, bus_err  out  1 each  sticky error flags.

Function
REQ-006 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 SHALL go to HALT on the next edge.
REQ-007 Opcode classes SHALL be R=0, I=1, LS=2, BR1=3, BR2=4, BR3=5, zero-extended to OPW bits.
REQ-008 In DECODE, opcode and funccode SHALL be latched into internal registers; all later outputs SHALL depend only on state, these registers and the timeout counter.
REQ-009 IDLE: all strobes SHALL be 0; the FSM SHALL go to FETCH when run=1.
REQ-010 FETCH: mem_read=1 and iord=0 SHALL hold until mem_ready=1; in that cycle ir_write=1 and pc_write=1, and the next state SHALL be DECODE.
REQ-011 DECODE: the next state SHALL be HALT if opcode=HALT_OP.
- Otherwise the next state SHALL be EXEC if the opcode is classes 0-5.
- Otherwise illegal SHALL be set and the next state SHALL be FETCH.
REQ-012 EXEC, R class: alu_op=01, alu_frc=0, alu_src=10 if funccode is 4, 6 or 8, else 00; the next state SHALL be WB.
REQ-013 EXEC, I class: alu_op=10, alu_src=01; the next state SHALL be WB.
REQ-014 EXEC, LS class: alu_op=11, alu_src=01, alu_frc=1; the next state SHALL be MEM.
REQ-015 EXEC, BR1/BR2/BR3: branch SHALL be 001/010/100 respectively, alu_op=00, and pc_write=1.
- br_link=1 SHALL apply for BR2 with funccode[2:0]=001, and the next state SHALL be WB.
- Otherwise the next state SHALL be FETCH.
REQ-016 MEM: iord=1, alu_frc=1, alu_op=11 throughout.
- funccode[0]=0 (load): mem_read=1 until mem_ready, then WB.
- funccode[0]=1 (store): mem_write=1 until mem_ready, then FETCH.
REQ-017 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for loads; br_link=1 for BR2 link.
REQ-018 instr_done SHALL pulse on the final cycle of every instruction (WB; store completion in MEM; non-link branch in EXEC); it SHALL NOT pulse on illegal opcodes.
REQ-019 On the instr_done cycle the next state SHALL be FETCH if run=1, else IDLE.
REQ-020 Timeout counter (clog2(MEM_TIMEOUT+1) bits):
- Clears on entry to FETCH and MEM, and counts each cycle waiting with mem_ready=0.
- On reaching MEM_TIMEOUT: set bus_err, drop all strobes, go to HALT.
- mem_ready=1 in the same cycle takes priority over the timeout.
REQ-021 HALT: all strobes SHALL be 0; HALT SHALL be left only by reset.
REQ-022 Any output not driven active in a state SHALL be 0.

Reset
REQ-023 rst=0 SHALL immediately force state=IDLE, clear the latched fields, the counter, illegal and bus_err, and drive every output to 0, including mid-access.
REQ-024 After rst rises, the first transition SHALL occur on the next clk edge with run=1.

Verification
REQ-025 R add (op 0, fn 0), mem_ready tied 1, run=1 -> states FETCH, DECODE, EXEC, WB over 4 cycles; alu_src=00, alu_op=01, reg_write=1 only in WB; instr_done in WB.
REQ-026 Load (op 2, fn 0), mem_ready delayed 3 cycles in MEM -> mem_read=1 and iord=1 for 4 cycles, then WB with mem_to_reg=1.
REQ-027 BR2 fn 001 -> EXEC: branch=010, pc_write=1; WB: reg_write=1 and br_link=1. BR1 -> FETCH directly after EXEC with instr_done in EXEC.
REQ-028 mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> bus_err=1 and state=HALT after 16 wait cycles; mem_ready=1 on cycle 16 -> normal DECODE.
REQ-029 Opcode 7 -> illegal=1, no instr_done, next FETCH. Opcode HALT_OP -> HALT is held; rst pulse -> IDLE with illegal=0.
REQ-030 rst asserted during a store in MEM -> mem_write drops to 0 before the next clk edge.
